rle_block_compressor: RTL

- Parametrised run-length compressor for fixed-size text blocks. Accepts one packed block of NUM_CHARS characters per valid/ready handshake.
- Emits a stream of (char, count) tokens with valid/ready backpressure and a last flag.
- Successor to the fixed 64-char block compressor path. Adds configurable char/block/count widths, a variable valid length per block, run saturation, a raw (bypass) mode and flow control on both sides.

---
 rtl/compress_pkg.sv | 21 ++
 rtl/rle_char_select.sv | 25 ++
 rtl/rle_block_compressor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/compress_pkg.sv
// Shared types and helpers for the run-length block compressor.
// Characters are packed MSB-first: char 0 occupies the top CHAR_W bits of a block.
package compress_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    // Largest count representable in a cnt_w-bit run counter.
    function automatic int max_run(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // LSB position of character idx inside a packed block (get_char = block[offset +: char_w]).
    function automatic int char_offset(input int num_chars, input int char_w, input int idx);
        return (num_chars - 1 - idx) * char_w;
    endfunction

endpackage

// File: rtl/rle_char_select.sv
// NUM_CHARS:1 character mux over a packed MSB-first block.
// Indices at or beyond NUM_CHARS select zero.
module rle_char_select
    import compress_pkg::*;
#(
    parameter int CHAR_W    = 8,
    parameter int NUM_CHARS = 64,
    parameter int IDX_W     = $clog2(NUM_CHARS + 1)
) (
    input  logic [NUM_CHARS*CHAR_W-1:0] block,
    input  logic [IDX_W-1:0]            idx,
    output logic [CHAR_W-1:0]           sel_char
);

    always_comb begin
        // NOTE: default first so every path assigns sel_char and no latch is inferred.
        sel_char = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_char = block[char_offset(NUM_CHARS, CHAR_W, i) +: CHAR_W];
            end
        end
    end

endmodule

// File: rtl/rle_block_compressor.sv
// Run-length compressor: one packed block in, a stream of (char, count) tokens out.
// Supports variable length per block, run saturation at MAX_RUN and a raw bypass mode.
module rle_block_compressor
    import compress_pkg::*;
#(
    parameter int CHAR_W    = 8,
    parameter int NUM_CHARS = 64,
    parameter int CNT_W     = 8,
    parameter int LEN_W     = $clog2(NUM_CHARS + 1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_CHARS*CHAR_W-1:0] in_block,
    input  logic [LEN_W-1:0]            in_len,
    input  logic                        in_raw,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHAR_W-1:0]           out_char,
    output logic [CNT_W-1:0]            out_count,
    output logic                        out_last,
    output logic                        busy
);

    localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));

    typedef struct packed {
        logic [CHAR_W-1:0] chr;
        logic [CNT_W-1:0]  count;
        logic              last;
    } token_t;

    state_t                      state_q, state_d;
    token_t                      tok_q, tok_d;
    logic [NUM_CHARS*CHAR_W-1:0] block_q, block_d;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        raw_q, raw_d;
    logic [CHAR_W-1:0]           cur_q, cur_d;
    logic [CNT_W-1:0]            run_q, run_d;
    logic [LEN_W-1:0]            idx_q, idx_d;

    logic [LEN_W-1:0]  len_clamped;
    logic [CHAR_W-1:0] first_char;
    logic [CHAR_W-1:0] sel_char;

    assign len_clamped = (in_len > LEN_W'(NUM_CHARS)) ? LEN_W'(NUM_CHARS) : in_len;
    assign first_char  = in_block[char_offset(NUM_CHARS, CHAR_W, 0) +: CHAR_W];

    // One mux serves both the SCAN compare and the EMIT reload; both read char[idx].
    rle_char_select #(
        .CHAR_W   (CHAR_W),
        .NUM_CHARS(NUM_CHARS),
        .IDX_W    (LEN_W)
    ) u_char_select (
        .block   (block_q),
        .idx     (idx_q),
        .sel_char(sel_char)
    );

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        block_d = block_q;
        len_d   = len_q;
        raw_d   = raw_q;
        cur_d   = cur_q;
        run_d   = run_q;
        idx_d   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    block_d = in_block;
                    len_d   = len_clamped;
                    raw_d   = in_raw;
                    if (len_clamped == '0) begin
                        tok_d   = '{chr: '0, count: '0, last: 1'b1};
                        state_d = EMIT;
                    end else begin
                        cur_d   = first_char;
                        run_d   = CNT_W'(1);
                        idx_d   = LEN_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (idx_q < len_q && sel_char == cur_q && run_q < MAX_RUN && !raw_q) begin
                    run_d = run_q + CNT_W'(1);
                    idx_d = idx_q + LEN_W'(1);
                end else begin
                    tok_d   = '{chr: cur_q, count: run_q, last: (idx_q == len_q)};
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (tok_q.last) begin
                        state_d = IDLE;
                    end else begin
                        cur_d   = sel_char;
                        run_d   = CNT_W'(1);
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
        end
    end

    // NOTE: datapath registers carry no reset; they are always written before being read.
    always_ff @(posedge CLK) begin
        block_q <= block_d;
        len_q   <= len_d;
        raw_q   <= raw_d;
        cur_q   <= cur_d;
        run_q   <= run_d;
        idx_q   <= idx_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == EMIT);
    assign out_char  = tok_q.chr;
    assign out_count = tok_q.count;
    assign out_last  = tok_q.last;

endmodule
